button_debounce: RTL and testbench

Debounced input front-end for the board's five pushbuttons and sixteen slide switches. It is the input-side counterpart of the seven-segment display driver and feeds the monitor and menu logic on the peripheral clock domain. Each input is synchronised and debounced against a shared prescaler tick. Switches are exposed as clean levels. Buttons also produce one-cycle press and release pulses and a small event queue drained through a valid/ready handshake.

---
 rtl/button_debounce_pkg.sv | 31 +++
 rtl/button_debounce_if.sv | 11 +
 rtl/button_debounce_debounce_cell.sv | 53 +++++
 rtl/button_debounce.sv | 188 ++++++++++++++++++
 tb/tb_button_debounce.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/button_debounce_pkg.sv
// rtl/button_debounce_pkg.sv - shared constants and event code layout for button_debounce
package button_debounce_pkg;

    localparam int NUM_BTN = 5;
    localparam int NUM_SW  = 16;

    localparam logic [1:0] EVT_PRESS   = 2'b01;
    localparam logic [1:0] EVT_RELEASE = 2'b10;
    localparam logic [1:0] EVT_REPEAT  = 2'b11;

    localparam logic [2:0] BTN_C = 3'd0;
    localparam logic [2:0] BTN_U = 3'd1;
    localparam logic [2:0] BTN_L = 3'd2;
    localparam logic [2:0] BTN_R = 3'd3;
    localparam logic [2:0] BTN_D = 3'd4;

    typedef struct packed {
        logic [1:0] kind;
        logic [2:0] idx;
    } evt_code_t;

    localparam int EVT_W = $bits(evt_code_t);

    function automatic evt_code_t make_evt(input logic [1:0] kind, input logic [2:0] idx);
        evt_code_t e;
        e.kind = kind;
        e.idx  = idx;
        return e;
    endfunction

endpackage

// File: rtl/button_debounce_if.sv
// rtl/button_debounce_if.sv - button event queue valid/ready handshake
interface button_debounce_if;
    import button_debounce_pkg::*;

    logic             evt_valid;
    logic [EVT_W-1:0] evt_code;
    logic             evt_ready;

    modport master (output evt_valid, output evt_code, input evt_ready);
    modport slave  (input evt_valid, input evt_code, output evt_ready);
endinterface

// File: rtl/button_debounce_debounce_cell.sv
// rtl/button_debounce_debounce_cell.sv - 2-FF synchroniser, tick-driven stability counter and level register
module debounce_cell
    import button_debounce_pkg::*;
#(
    parameter int STABLE = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick_i,
    input  logic raw_i,
    output logic level_o,
    output logic toggle_o
);
    localparam int CW = (STABLE > 1) ? $clog2(STABLE) : 1;

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // toggle_o flags the cycle whose edge flips the level, so callers can register pulses alongside it
    always_comb begin
        cnt_d    = cnt_q;
        level_d  = level_q;
        toggle_o = 1'b0;
        if (tick_i) begin
            if (sync2_q == level_q) begin
                cnt_d = '0;
            end else if (cnt_q == CW'(STABLE - 1)) begin
                level_d  = sync2_q;
                cnt_d    = '0;
                toggle_o = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;
endmodule

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - debounced buttons/switches with press/release pulses and a 4-entry event queue
// Optional auto-repeat events are built when BUTTON_DEBOUNCE_REPEAT_EN is defined.
module button_debounce
    import button_debounce_pkg::*;
#(
    parameter int DIV          = 12,
    parameter int STABLE       = 4,
    parameter int REPEAT_DELAY = 64,
    parameter int REPEAT_RATE  = 16
) (
    input  logic                clk_peripheral,
    input  logic                reset_n,
    input  logic [NUM_BTN-1:0]  btn,
    input  logic [NUM_SW-1:0]   sw,
    output logic [NUM_BTN-1:0]  btn_level,
    output logic [NUM_SW-1:0]   sw_level,
    output logic [NUM_BTN-1:0]  btn_press,
    output logic [NUM_BTN-1:0]  btn_release,
    button_debounce_if.master   evt,
    output logic                overflow,
    input  logic                overflow_clr
);
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    logic [DIV-1:0]     div_q;
    logic               tick;
    logic [NUM_BTN-1:0] btn_lvl, btn_tog;
    logic [NUM_SW-1:0]  sw_tog_unused;

    always_ff @(posedge clk_peripheral or negedge reset_n) begin
        if (!reset_n) div_q <= '0;
        else          div_q <= div_q + 1'b1;
    end
    assign tick = &div_q;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        debounce_cell #(.STABLE(STABLE)) u_cell (
            .clk(clk_peripheral), .rst_n(reset_n), .tick_i(tick),
            .raw_i(btn[i]), .level_o(btn_lvl[i]), .toggle_o(btn_tog[i])
        );
    end
    for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
        debounce_cell #(.STABLE(STABLE)) u_cell (
            .clk(clk_peripheral), .rst_n(reset_n), .tick_i(tick),
            .raw_i(sw[i]), .level_o(sw_level[i]), .toggle_o(sw_tog_unused[i])
        );
    end

    logic [NUM_BTN-1:0] press_q, release_q;
    logic [NUM_BTN-1:0] press_pend_q, press_pend_d, press_clr;
    logic [NUM_BTN-1:0] rel_pend_q, rel_pend_d, rel_clr;
    logic [NUM_BTN-1:0] rpt_pend_q, rpt_pend_d, rpt_clr, rpt_hit;
    logic               sel_valid;
    evt_code_t          sel_code;

`ifdef BUTTON_DEBOUNCE_REPEAT_EN
    logic [RPT_W-1:0]   rpt_cnt_q [NUM_BTN];
    logic [RPT_W-1:0]   rpt_cnt_d [NUM_BTN];
    logic [NUM_BTN-1:0] rpt_first_q, rpt_first_d;
    logic [RPT_W-1:0]   rpt_target;

    // rpt_first selects the initial delay; after the first repeat the shorter rate applies
    always_comb begin
        rpt_hit     = '0;
        rpt_first_d = rpt_first_q;
        rpt_target  = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            rpt_cnt_d[i] = rpt_cnt_q[i];
            rpt_target   = rpt_first_q[i] ? RPT_W'(REPEAT_DELAY) : RPT_W'(REPEAT_RATE);
            if (btn_tog[i] && !btn_lvl[i]) begin
                rpt_cnt_d[i]   = '0;
                rpt_first_d[i] = 1'b1;
            end else if (tick && btn_lvl[i] && !btn_tog[i]) begin
                if (rpt_cnt_q[i] + 1'b1 == rpt_target) begin
                    rpt_hit[i]     = 1'b1;
                    rpt_cnt_d[i]   = '0;
                    rpt_first_d[i] = 1'b0;
                end else begin
                    rpt_cnt_d[i] = rpt_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_peripheral or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_BTN; i++) rpt_cnt_q[i] <= '0;
            rpt_first_q <= '1;
        end else begin
            for (int i = 0; i < NUM_BTN; i++) rpt_cnt_q[i] <= rpt_cnt_d[i];
            rpt_first_q <= rpt_first_d;
        end
    end
`else
    logic [RPT_W-1:0] rpt_cfg_unused;
    assign rpt_cfg_unused = '0;
    assign rpt_hit        = '0;
`endif

    // Lowest button first, press before release for one button; repeats only when nothing else waits
    always_comb begin
        sel_valid = 1'b0;
        sel_code  = '0;
        press_clr = '0;
        rel_clr   = '0;
        rpt_clr   = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            if (!sel_valid && press_pend_q[i]) begin
                sel_valid    = 1'b1;
                sel_code     = make_evt(EVT_PRESS, 3'(i));
                press_clr[i] = 1'b1;
            end
            if (!sel_valid && rel_pend_q[i]) begin
                sel_valid  = 1'b1;
                sel_code   = make_evt(EVT_RELEASE, 3'(i));
                rel_clr[i] = 1'b1;
            end
        end
        for (int i = 0; i < NUM_BTN; i++) begin
            if (!sel_valid && rpt_pend_q[i]) begin
                sel_valid  = 1'b1;
                sel_code   = make_evt(EVT_REPEAT, 3'(i));
                rpt_clr[i] = 1'b1;
            end
        end
    end

    assign press_pend_d = (press_pend_q & ~press_clr) | (btn_tog & ~btn_lvl);
    assign rel_pend_d   = (rel_pend_q & ~rel_clr) | (btn_tog & btn_lvl);
    assign rpt_pend_d   = (rpt_pend_q & ~rpt_clr) | rpt_hit;

    logic       push_valid_q;
    evt_code_t  push_code_q;
    evt_code_t  mem_q [4];
    logic [1:0] wr_ptr_q, rd_ptr_q;
    logic [2:0] count_q;
    logic       full, pop, do_push, drop, ovf_q;

    assign full    = (count_q == 3'd4);
    assign pop     = (count_q != 3'd0) && evt.evt_ready;
    assign do_push = push_valid_q && (!full || pop);
    assign drop    = push_valid_q && full && !pop;

    always_ff @(posedge clk_peripheral or negedge reset_n) begin
        if (!reset_n) begin
            press_q      <= '0;
            release_q    <= '0;
            press_pend_q <= '0;
            rel_pend_q   <= '0;
            rpt_pend_q   <= '0;
            push_valid_q <= 1'b0;
            push_code_q  <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            ovf_q        <= 1'b0;
        end else begin
            press_q      <= btn_tog & ~btn_lvl;
            release_q    <= btn_tog & btn_lvl;
            press_pend_q <= press_pend_d;
            rel_pend_q   <= rel_pend_d;
            rpt_pend_q   <= rpt_pend_d;
            push_valid_q <= sel_valid;
            push_code_q  <= sel_code;
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (drop)              ovf_q <= 1'b1;
            else if (overflow_clr) ovf_q <= 1'b0;
        end
    end

    always_ff @(posedge clk_peripheral) begin
        if (do_push) mem_q[wr_ptr_q] <= push_code_q;
    end

    assign evt.evt_valid = (count_q != 3'd0);
    assign evt.evt_code  = evt.evt_valid ? mem_q[rd_ptr_q] : '0;
    assign btn_level     = btn_lvl;
    assign btn_press     = press_q;
    assign btn_release   = release_q;
    assign overflow      = ovf_q;
endmodule

// File: tb/tb_button_debounce.sv
// tb/tb_button_debounce.sv - directed self-checking bench for button_debounce
module tb_button_debounce;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [4:0]  btn;
    logic [15:0] sw;
    logic [4:0]  btn_level, btn_press, btn_release;
    logic [15:0] sw_level;
    logic        overflow, overflow_clr;
    int          vectors = 0;
    int          miscompares = 0;

    button_debounce_if evt_if();

    button_debounce #(.DIV(2), .STABLE(3), .REPEAT_DELAY(4), .REPEAT_RATE(2)) dut (
        .clk_peripheral(clk), .reset_n(reset_n), .btn(btn), .sw(sw),
        .btn_level(btn_level), .sw_level(sw_level), .btn_press(btn_press),
        .btn_release(btn_release), .evt(evt_if), .overflow(overflow),
        .overflow_clr(overflow_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_press(input int idx, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            if (btn_press[idx]) ok = 1'b1;
        end
    endtask

    task automatic wait_release(input int idx, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            if (btn_release[idx]) ok = 1'b1;
        end
    endtask

    initial begin
        logic       ok;
        logic       seen;
        int         rpt_n;
        int         rpt_at [3];

        reset_n = 1'b0; btn = '0; sw = 16'hA5A5;
        overflow_clr = 1'b0; evt_if.evt_ready = 1'b0;
        rpt_n = 0; rpt_at = '{0, 0, 0};

        // reset state
        cyc(3);
        chk("rst_btn_level", btn_level, 0);
        chk("rst_sw_level", sw_level, 0);
        chk("rst_pulses", {btn_press, btn_release}, 0);
        chk("rst_evt_valid", evt_if.evt_valid, 0);
        chk("rst_overflow", overflow, 0);

        reset_n = 1'b1;
        cyc(18);
        chk("sw_level_after_rst", sw_level, 16'hA5A5);
        chk("no_evt_after_rst", evt_if.evt_valid, 0);

        // short glitch on btn[1]
        seen = 1'b0;
        btn[1] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            seen = seen | (|btn_level) | (|btn_press) | evt_if.evt_valid;
        end
        btn[1] = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            seen = seen | (|btn_level) | (|btn_press) | evt_if.evt_valid;
        end
        chk("glitch_ignored", seen, 0);

        // btn[0] press then release
        btn[0] = 1'b1;
        wait_press(0, ok);
        chk("press0_seen", ok, 1);
        chk("press0_level", btn_level, 5'b00001);
        chk("press0_no_evt_yet", evt_if.evt_valid, 0);
        cyc(1);
        chk("press0_pulse_one_cycle", btn_press, 0);
        chk("press0_evt_e1", evt_if.evt_valid, 0);
        cyc(1);
        chk("press0_evt_valid", evt_if.evt_valid, 1);
        chk("press0_evt_code", evt_if.evt_code, 5'b01_000);
        evt_if.evt_ready = 1'b1;
        cyc(1);
        evt_if.evt_ready = 1'b0;
        chk("press0_popped", evt_if.evt_valid, 0);
        btn[0] = 1'b0;
        wait_release(0, ok);
        chk("release0_seen", ok, 1);
        cyc(2);
        chk("release0_evt_code", {evt_if.evt_valid, evt_if.evt_code}, 6'b1_10_000);
        evt_if.evt_ready = 1'b1;
        cyc(1);
        evt_if.evt_ready = 1'b0;

        // btn[2] and btn[4] on the same tick
        btn = 5'b10100;
        wait_press(2, ok);
        chk("dual_press_seen", ok, 1);
        chk("dual_press_pulses", btn_press, 5'b10100);
        cyc(2);
        chk("dual_first", {evt_if.evt_valid, evt_if.evt_code}, 6'b1_01_010);
        evt_if.evt_ready = 1'b1;
        cyc(1);
        chk("dual_second", {evt_if.evt_valid, evt_if.evt_code}, 6'b1_01_100);
        cyc(1);
        chk("dual_drained", evt_if.evt_valid, 0);
        evt_if.evt_ready = 1'b0;

        // five events into a 4-deep queue
        btn = 5'b01011;
        wait_press(0, ok);
        chk("burst_seen", ok, 1);
        cyc(6);
        chk("burst_overflow", overflow, 1);
        chk("burst_head", {evt_if.evt_valid, evt_if.evt_code}, 6'b1_01_000);

        // sixth drop coincides with overflow_clr: set wins
        btn = 5'b01010;
        wait_release(0, ok);
        chk("drop6_seen", ok, 1);
        cyc(1);
        overflow_clr = 1'b1;
        cyc(1);
        overflow_clr = 1'b0;
        chk("ovf_set_beats_clr", overflow, 1);
        overflow_clr = 1'b1;
        cyc(1);
        overflow_clr = 1'b0;
        chk("ovf_cleared", overflow, 0);

        chk("drain0", {evt_if.evt_valid, evt_if.evt_code}, 6'b1_01_000);
        evt_if.evt_ready = 1'b1;
        cyc(1);
        chk("drain1", {evt_if.evt_valid, evt_if.evt_code}, 6'b1_01_001);
        cyc(1);
        chk("drain2", {evt_if.evt_valid, evt_if.evt_code}, 6'b1_10_010);
        cyc(1);
        chk("drain3", {evt_if.evt_valid, evt_if.evt_code}, 6'b1_01_011);
        cyc(1);
        chk("drain_empty", evt_if.evt_valid, 0);
        evt_if.evt_ready = 1'b0;

        // reset mid-hold with an event queued
        btn = 5'b01000;
        wait_release(1, ok);
        chk("release1_seen", ok, 1);
        cyc(2);
        chk("release1_queued", {evt_if.evt_valid, evt_if.evt_code}, 6'b1_10_001);
        reset_n = 1'b0;
        #1;
        chk("async_rst_queue", evt_if.evt_valid, 0);
        chk("async_rst_level", btn_level, 0);
        cyc(2);
        reset_n = 1'b1;
        wait_press(3, ok);
        chk("held_through_rst_press", ok, 1);
        cyc(2);
        chk("held_press_evt", {evt_if.evt_valid, evt_if.evt_code}, 6'b1_01_011);
        evt_if.evt_ready = 1'b1;
`ifdef BUTTON_DEBOUNCE_REPEAT_EN
        for (int i = 3; i <= 38; i++) begin
            @(negedge clk);
            if (evt_if.evt_valid && evt_if.evt_code == 5'b11_011) begin
                if (rpt_n < 3) rpt_at[rpt_n] = i;
                rpt_n++;
            end
        end
        chk("repeat_count", rpt_n, 3);
        chk("repeat_at_tick4", rpt_at[0], 18);
        chk("repeat_at_tick6", rpt_at[1], 26);
        chk("repeat_at_tick8", rpt_at[2], 34);
`else
        cyc(1);
        chk("held_press_popped", evt_if.evt_valid, 0);
`endif
        evt_if.evt_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
